// File: rtl/irq_ctrl_n_pkg.sv
// Shared definitions for the irq_ctrl_n interrupt controller: register word
// offsets within the 4-word window and the request FSM state encoding.
package irq_ctrl_n_pkg;

  localparam logic [1:0] IRQC_ENABLE  = 2'd0;
  localparam logic [1:0] IRQC_PENDING = 2'd1;
  localparam logic [1:0] IRQC_MODE    = 2'd2;
  localparam logic [1:0] IRQC_CLAIM   = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// request bit plus a valid flag. Purely combinational.
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    id_o    = '0;
    valid_o = |req_i;
    // Scan downwards so the lowest set index is the last one assigned.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl_n.sv
// Parametrised interrupt controller: latches sources into pending bits, masks
// them with ENABLE and presents one fixed-priority request to the core.
module irq_ctrl_n
  import irq_ctrl_n_pkg::*;
#(
  parameter int unsigned         NUM_SRC   = 8,
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'h4000_0000,
  localparam int unsigned        ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               irq_ack_i
);

  logic [NUM_SRC-1:0] r_enable, r_pending, r_mode, r_src_d1;
  logic [NUM_SRC-1:0] w_enable_d, w_pending_d, w_set, w_clr, w_masked;
  logic [DATA_W-1:0]  r_rdata, w_rdata;
  logic [ID_W-1:0]    r_irq_id, w_win_id;
  logic               r_irq, w_valid, w_in_win, w_ack_take;
  logic               w_wr_enable, w_wr_pending, w_wr_mode;
  logic [1:0]         w_word;
  irq_state_e         r_state;
  logic               w_unused;

  assign w_unused = ^{addr_i[1:0], wdata_i};

  // Window assumed 16-byte aligned; the low address bits select the word.
  assign w_in_win     = (addr_i[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign w_word       = addr_i[3:2];
  assign w_wr_enable  = wr_en_i && w_in_win && (w_word == IRQC_ENABLE);
  assign w_wr_pending = wr_en_i && w_in_win && (w_word == IRQC_PENDING);
  assign w_wr_mode    = wr_en_i && w_in_win && (w_word == IRQC_MODE);
  assign w_ack_take   = (r_state == StReq) && irq_ack_i;
  assign w_masked     = r_pending & r_enable;

  always_comb begin
    w_set = (r_mode & irq_src_i & ~r_src_d1) | (~r_mode & irq_src_i);
    w_clr = '0;
    if (w_wr_pending) w_clr = wdata_i[NUM_SRC-1:0];
    if (w_ack_take)   w_clr[r_irq_id] = 1'b1;
    // Set is applied last so a new event beats a same-cycle clear.
    w_pending_d = (r_pending & ~w_clr) | w_set;
    w_enable_d  = w_wr_enable ? wdata_i[NUM_SRC-1:0] : r_enable;
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      IRQC_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
      IRQC_PENDING: w_rdata[NUM_SRC-1:0] = r_pending;
      IRQC_MODE:    w_rdata[NUM_SRC-1:0] = r_mode;
      default: begin
        w_rdata[ID_W-1:0]   = r_irq_id;
        w_rdata[DATA_W-1]   = r_irq;
      end
    endcase
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req_i   (w_masked),
    .valid_o (w_valid),
    .id_o    (w_win_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enable  <= '0;
      r_pending <= '0;
      r_mode    <= '0;
      r_src_d1  <= '0;
      r_rdata   <= '0;
    end else begin
      r_enable  <= w_enable_d;
      r_pending <= w_pending_d;
      r_src_d1  <= irq_src_i;
      if (w_wr_mode) r_mode <= wdata_i[NUM_SRC-1:0];
      r_rdata   <= (rd_en_i && w_in_win) ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_state  <= StReq;
            r_irq    <= 1'b1;
            r_irq_id <= w_win_id;
          end
        end
        StReq: begin
          if (irq_ack_i) begin
            r_state <= StGap;
            r_irq   <= 1'b0;
          end else if (!(w_enable_d[r_irq_id] && w_pending_d[r_irq_id])) begin
            // Software withdrew the request before the core took it.
            r_state <= StIdle;
            r_irq   <= 1'b0;
          end
        end
        StGap: begin
          r_state <= StIdle;
          r_irq   <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o  = r_rdata;
  assign irq_o    = r_irq;
  assign irq_id_o = r_irq_id;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Directed self-checking bench for irq_ctrl_n (NUM_SRC=8, base 0x4000_0000).
module tb_irq_ctrl_n;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_EN = BASE + 32'h0;
  localparam logic [31:0] A_PD = BASE + 32'h4;
  localparam logic [31:0] A_MD = BASE + 32'h8;
  localparam logic [31:0] A_CL = BASE + 32'hC;
  localparam logic [31:0] A_OUT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic [2:0]  irq_id;
  logic        ack = 1'b0;
  logic [31:0] rv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl_n #(
    .NUM_SRC   (8),
    .DATA_W    (32),
    .ADDR_W    (32),
    .BASE_ADDR (32'h4000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src_i (irq_src),
    .wr_en_i   (wr_en),
    .rd_en_i   (rd_en),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .irq_o     (irq),
    .irq_id_o  (irq_id),
    .irq_ack_i (ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_en = 1'b1;
    addr  = a;
    tick();
    d     = rdata;
    rd_en = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_id", {29'b0, irq_id}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rd(A_EN, rv);
    chk("rst_enable", rv, 32'h0);

    // 1: single edge source
    wr(A_EN, 32'h01);
    wr(A_MD, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    chk("t1_irq_n1", {31'b0, irq}, 32'h0);
    tick();
    chk("t1_irq_n2", {31'b0, irq}, 32'h1);
    chk("t1_id", {29'b0, irq_id}, 32'h0);
    ack_pulse();
    chk("t1_irq_gap", {31'b0, irq}, 32'h0);
    rd(A_PD, rv);
    chk("t1_pending", rv, 32'h0);

    // 2: two simultaneous edges, lowest index first
    wr(A_EN, 32'hFF);
    wr(A_MD, 32'hFF);
    irq_src = 8'h24;
    tick();
    irq_src = 8'h00;
    tick();
    chk("t2_irq_a", {31'b0, irq}, 32'h1);
    chk("t2_id_a", {29'b0, irq_id}, 32'h2);
    ack_pulse();
    chk("t2_gap", {31'b0, irq}, 32'h0);
    tick();
    tick();
    chk("t2_irq_b", {31'b0, irq}, 32'h1);
    chk("t2_id_b", {29'b0, irq_id}, 32'h5);
    ack_pulse();
    tick();

    // 3: level source re-requests after the gap
    wr(A_MD, 32'h00);
    wr(A_EN, 32'h08);
    irq_src = 8'h08;
    tick();
    tick();
    chk("t3_irq_a", {31'b0, irq}, 32'h1);
    chk("t3_id_a", {29'b0, irq_id}, 32'h3);
    ack_pulse();
    chk("t3_gap", {31'b0, irq}, 32'h0);
    tick();
    tick();
    chk("t3_irq_b", {31'b0, irq}, 32'h1);
    chk("t3_id_b", {29'b0, irq_id}, 32'h3);
    irq_src = 8'h00;
    ack_pulse();
    tick();
    tick();
    chk("t3_idle", {31'b0, irq}, 32'h0);
    rd(A_PD, rv);
    chk("t3_pending", rv, 32'h0);

    // 4: disabled source still latches pending
    wr(A_EN, 32'h00);
    wr(A_MD, 32'h80);
    irq_src = 8'h80;
    tick();
    irq_src = 8'h00;
    tick();
    chk("t4_masked_irq", {31'b0, irq}, 32'h0);
    rd(A_PD, rv);
    chk("t4_pending", rv, 32'h80);
    wr(A_EN, 32'h80);
    tick();
    chk("t4_irq", {31'b0, irq}, 32'h1);
    chk("t4_id", {29'b0, irq_id}, 32'h7);
    rd(A_CL, rv);
    chk("t4_claim", rv, 32'h8000_0007);
    rd(A_OUT, rv);
    chk("t4_out_rd", rv, 32'h0);
    wr(A_OUT, 32'hFF);
    rd(A_EN, rv);
    chk("t4_out_wr", rv, 32'h80);
    ack_pulse();
    tick();

    // 5: software W1C withdraws a pending request
    wr(A_MD, 32'h10);
    wr(A_EN, 32'h10);
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    tick();
    chk("t5_irq", {31'b0, irq}, 32'h1);
    chk("t5_id", {29'b0, irq_id}, 32'h4);
    wr(A_PD, 32'h10);
    chk("t5_drop", {31'b0, irq}, 32'h0);
    ack_pulse();
    tick();
    chk("t5_idle_ack", {31'b0, irq}, 32'h0);
    rd(A_EN, rv);
    chk("t5_enable", rv, 32'h10);
    rd(A_PD, rv);
    chk("t5_pending", rv, 32'h0);

    // 6: reset while a request is outstanding
    wr(A_MD, 32'h06);
    wr(A_EN, 32'h06);
    irq_src = 8'h06;
    tick();
    irq_src = 8'h00;
    tick();
    chk("t6_irq", {31'b0, irq}, 32'h1);
    chk("t6_id", {29'b0, irq_id}, 32'h1);
    rst_n = 1'b0;
    rd_en = 1'b1;
    addr  = A_PD;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b1;
    chk("t6_rst_irq", {31'b0, irq}, 32'h0);
    chk("t6_rst_id", {29'b0, irq_id}, 32'h0);
    chk("t6_rst_rdata", rdata, 32'h0);
    rd(A_PD, rv);
    chk("t6_pending", rv, 32'h0);
    rd(A_EN, rv);
    chk("t6_enable", rv, 32'h0);
    rd(A_MD, rv);
    chk("t6_mode", rv, 32'h0);
    rd(A_CL, rv);
    chk("t6_claim", rv, 32'h0);
    tick();
    chk("t6_still_idle", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
